// File: rtl/ram_dma_pkg.sv
// Shared types for the ram_dma copy/fill engine: FSM states and command modes.
package ram_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        FIN
    } state_t;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_t;

endpackage

// File: rtl/ram_dma.sv
// Memory copy/fill engine driving a synchronous RAM port; copies take
// read/capture/write per word, fills write one word per cycle.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_x,
    input  logic [DATA_WIDTH-1:0] mem_y
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state;
    mode_t                 mode_q;
    mode_t                 mode_in;
    logic                  dir_down;
    logic                  down_in;
    logic [DATA_WIDTH-1:0] pat_q;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] sp;
    logic [ADDR_WIDTH-1:0] dp;
    logic [ADDR_WIDTH-1:0] sp_init;
    logic [ADDR_WIDTH-1:0] dp_init;
    logic [ADDR_WIDTH-1:0] sp_next;
    logic [ADDR_WIDTH-1:0] dp_next;

    // A copy whose destination lies above its source walks from the top end
    // down, so overlapping source words are read before they are overwritten.
    always_comb begin
        mode_in = mode_t'(mode);
        down_in = (mode_in == MODE_COPY) && (dst > src);
        sp_init = down_in ? (src + len - ONE) : src;
        dp_init = down_in ? (dst + len - ONE) : dst;
        sp_next = dir_down ? (sp - ONE) : (sp + ONE);
        dp_next = dir_down ? (dp - ONE) : (dp + ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= MODE_COPY;
            dir_down <= 1'b0;
            pat_q    <= '0;
            cnt      <= '0;
            sp       <= '0;
            dp       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            mem_a    <= '0;
            mem_x    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode_in;
                        pat_q    <= pattern;
                        cnt      <= len;
                        dir_down <= down_in;
                        sp       <= sp_init;
                        dp       <= dp_init;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (mode_in == MODE_FILL) begin
                            state  <= WR;
                            busy   <= 1'b1;
                            mem_we <= 1'b1;
                            mem_a  <= dp_init;
                            mem_x  <= pattern;
                        end else begin
                            state  <= RD;
                            busy   <= 1'b1;
                            mem_re <= 1'b1;
                            mem_a  <= sp_init;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                // The RAM output register is valid now; it becomes the write data.
                CAP: begin
                    state  <= WR;
                    mem_re <= 1'b0;
                    mem_we <= 1'b1;
                    mem_a  <= dp;
                    mem_x  <= mem_y;
                end
                WR: begin
                    cnt <= cnt - ONE;
                    sp  <= sp_next;
                    dp  <= dp_next;
                    if (cnt == ONE) begin
                        state  <= FIN;
                        busy   <= 1'b0;
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                    end else if (mode_q == MODE_COPY) begin
                        state  <= RD;
                        mem_we <= 1'b0;
                        mem_re <= 1'b1;
                        mem_a  <= sp_next;
                    end else begin
                        mem_a <= dp_next;
                        mem_x <= pat_q;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                end
            endcase
        end
    end

endmodule
